parking_gate_ctrl: RTL and testbench

// Gate sequencer that drives the event side of the parking counter. Turns raw

---
 rtl/parking_gate_ctrl_if.sv | 38 +++
 rtl/parking_gate_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/parking_gate_ctrl_if.sv
// Lane sensor / counter-event bundle between the gate sequencer and its environment.
interface parking_gate_ctrl_if;
  logic       entry_req;
  logic       entry_is_uni;
  logic       entry_pass;
  logic       exit_req;
  logic       exit_is_uni;
  logic       exit_pass;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic [4:0] hour;
  logic       entry_gate_open;
  logic       exit_gate_open;
  logic       entry_denied;
  logic       gate_timeout;

  // Environment side: drives sensors and vacancy flags, observes events.
  modport master (
    output entry_req, entry_is_uni, entry_pass,
    output exit_req, exit_is_uni, exit_pass,
    output uni_is_vacated_space, is_vacated_space,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    input  hour, entry_gate_open, exit_gate_open, entry_denied, gate_timeout
  );

  // Sequencer side.
  modport slave (
    input  entry_req, entry_is_uni, entry_pass,
    input  exit_req, exit_is_uni, exit_pass,
    input  uni_is_vacated_space, is_vacated_space,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    output hour, entry_gate_open, exit_gate_open, entry_denied, gate_timeout
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Gate sequencer: turns lane sensors into single-cycle entry/exit events for the
// parking counter, gates entry on vacancy, and keeps a free-running hour bus.
module parking_gate_ctrl #(
  parameter int START_HOUR     = 8,
  parameter int TICKS_PER_HOUR = 60,
  parameter int OPEN_TIMEOUT   = 32,
  parameter int DENY_CYCLES    = 4
) (
  input  logic               clk,
  input  logic               rst,
  parking_gate_ctrl_if.slave bus
);
  localparam int TICK_W = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
  localparam int TMR_W  = $clog2(OPEN_TIMEOUT);
  localparam int DNY_W  = (DENY_CYCLES > 1) ? $clog2(DENY_CYCLES) : 1;

  typedef enum logic [2:0] {E_IDLE, E_CHECK, E_OPEN, E_DENY, E_POST} entry_state_t;
  typedef enum logic [1:0] {X_IDLE, X_OPEN, X_POST} exit_state_t;

  entry_state_t      entry_state_q, entry_state_d;
  exit_state_t       exit_state_q, exit_state_d;
  logic              entry_req_q, entry_req_d, entry_req_prev_q, entry_req_prev_d;
  logic              exit_req_q, exit_req_d, exit_req_prev_q, exit_req_prev_d;
  logic              entry_uni_s_q, entry_uni_s_d, exit_uni_s_q, exit_uni_s_d;
  logic              entry_pass_q, entry_pass_d, exit_pass_q, exit_pass_d;
  logic              entry_tag_q, entry_tag_d, exit_tag_q, exit_tag_d;
  logic [TMR_W-1:0]  entry_timer_q, entry_timer_d, exit_timer_q, exit_timer_d;
  logic [DNY_W-1:0]  deny_cnt_q, deny_cnt_d;
  logic              car_entered_q, car_entered_d, uni_entered_q, uni_entered_d;
  logic              car_exited_q, car_exited_d, uni_exited_q, uni_exited_d;
  logic              entry_open_q, entry_open_d, exit_open_q, exit_open_d;
  logic              denied_q, denied_d, timeout_q, timeout_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [4:0]        hour_q, hour_d;
  logic              entry_rise, exit_rise, entry_grant, exit_grant;
  logic              entry_to, exit_to;

  assign entry_rise  = entry_req_q & ~entry_req_prev_q;
  assign exit_rise   = exit_req_q & ~exit_req_prev_q;
  // Exit wins a simultaneous event; the entry POST state simply waits a cycle.
  assign exit_grant  = (exit_state_q == X_POST);
  assign entry_grant = (entry_state_q == E_POST) && !exit_grant;

  // Next-state and registered-output logic for both gates, arbiter and hour clock.
  always_comb begin
    entry_req_d      = bus.entry_req;
    entry_req_prev_d = entry_req_q;
    exit_req_d       = bus.exit_req;
    exit_req_prev_d  = exit_req_q;
    entry_uni_s_d    = bus.entry_is_uni;
    exit_uni_s_d     = bus.exit_is_uni;
    entry_pass_d     = bus.entry_pass;
    exit_pass_d      = bus.exit_pass;
    entry_state_d    = entry_state_q;
    exit_state_d     = exit_state_q;
    entry_tag_d      = entry_tag_q;
    exit_tag_d       = exit_tag_q;
    entry_timer_d    = entry_timer_q;
    exit_timer_d     = exit_timer_q;
    deny_cnt_d       = deny_cnt_q;
    entry_to         = 1'b0;
    exit_to          = 1'b0;

    case (entry_state_q)
      E_IDLE:
        if (entry_rise) begin
          entry_state_d = E_CHECK;
          entry_tag_d   = entry_uni_s_q;
        end
      E_CHECK:
        if (entry_tag_q ? bus.uni_is_vacated_space : bus.is_vacated_space) begin
          entry_state_d = E_OPEN;
          entry_timer_d = '0;
        end else begin
          entry_state_d = E_DENY;
          deny_cnt_d    = '0;
        end
      E_OPEN:
        if (entry_pass_q) begin
          entry_state_d = E_POST;
        end else if (entry_timer_q == TMR_W'(OPEN_TIMEOUT - 1)) begin
          entry_state_d = E_IDLE;
          entry_to      = 1'b1;
        end else begin
          entry_timer_d = entry_timer_q + TMR_W'(1);
        end
      E_DENY:
        if (deny_cnt_q == DNY_W'(DENY_CYCLES - 1)) entry_state_d = E_IDLE;
        else deny_cnt_d = deny_cnt_q + DNY_W'(1);
      E_POST:
        if (entry_grant) entry_state_d = E_IDLE;
      default: entry_state_d = E_IDLE;
    endcase

    case (exit_state_q)
      X_IDLE:
        if (exit_rise) begin
          exit_state_d = X_OPEN;
          exit_tag_d   = exit_uni_s_q;
          exit_timer_d = '0;
        end
      X_OPEN:
        if (exit_pass_q) begin
          exit_state_d = X_POST;
        end else if (exit_timer_q == TMR_W'(OPEN_TIMEOUT - 1)) begin
          exit_state_d = X_IDLE;
          exit_to      = 1'b1;
        end else begin
          exit_timer_d = exit_timer_q + TMR_W'(1);
        end
      X_POST:
        if (exit_grant) exit_state_d = X_IDLE;
      default: exit_state_d = X_IDLE;
    endcase

    entry_open_d  = (entry_state_d == E_OPEN);
    exit_open_d   = (exit_state_d == X_OPEN);
    denied_d      = (entry_state_d == E_DENY);
    car_entered_d = entry_grant;
    uni_entered_d = entry_grant & entry_tag_q;
    car_exited_d  = exit_grant;
    uni_exited_d  = exit_grant & exit_tag_q;
    timeout_d     = entry_to | exit_to;

    if (tick_q == TICK_W'(TICKS_PER_HOUR - 1)) begin
      tick_d = '0;
      hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    end else begin
      tick_d = tick_q + TICK_W'(1);
      hour_d = hour_q;
    end
  end

  // State and output registers; edge detectors reload from live inputs on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_req_q      <= bus.entry_req;
      entry_req_prev_q <= bus.entry_req;
      exit_req_q       <= bus.exit_req;
      exit_req_prev_q  <= bus.exit_req;
      entry_uni_s_q    <= 1'b0;
      exit_uni_s_q     <= 1'b0;
      entry_pass_q     <= 1'b0;
      exit_pass_q      <= 1'b0;
      entry_state_q    <= E_IDLE;
      exit_state_q     <= X_IDLE;
      entry_tag_q      <= 1'b0;
      exit_tag_q       <= 1'b0;
      entry_timer_q    <= '0;
      exit_timer_q     <= '0;
      deny_cnt_q       <= '0;
      car_entered_q    <= 1'b0;
      uni_entered_q    <= 1'b0;
      car_exited_q     <= 1'b0;
      uni_exited_q     <= 1'b0;
      entry_open_q     <= 1'b0;
      exit_open_q      <= 1'b0;
      denied_q         <= 1'b0;
      timeout_q        <= 1'b0;
      tick_q           <= '0;
      hour_q           <= 5'(START_HOUR);
    end else begin
      entry_req_q      <= entry_req_d;
      entry_req_prev_q <= entry_req_prev_d;
      exit_req_q       <= exit_req_d;
      exit_req_prev_q  <= exit_req_prev_d;
      entry_uni_s_q    <= entry_uni_s_d;
      exit_uni_s_q     <= exit_uni_s_d;
      entry_pass_q     <= entry_pass_d;
      exit_pass_q      <= exit_pass_d;
      entry_state_q    <= entry_state_d;
      exit_state_q     <= exit_state_d;
      entry_tag_q      <= entry_tag_d;
      exit_tag_q       <= exit_tag_d;
      entry_timer_q    <= entry_timer_d;
      exit_timer_q     <= exit_timer_d;
      deny_cnt_q       <= deny_cnt_d;
      car_entered_q    <= car_entered_d;
      uni_entered_q    <= uni_entered_d;
      car_exited_q     <= car_exited_d;
      uni_exited_q     <= uni_exited_d;
      entry_open_q     <= entry_open_d;
      exit_open_q      <= exit_open_d;
      denied_q         <= denied_d;
      timeout_q        <= timeout_d;
      tick_q           <= tick_d;
      hour_q           <= hour_d;
    end
  end

  assign bus.car_entered        = car_entered_q;
  assign bus.is_uni_car_entered = uni_entered_q;
  assign bus.car_exited         = car_exited_q;
  assign bus.is_uni_car_exited  = uni_exited_q;
  assign bus.hour               = hour_q;
  assign bus.entry_gate_open    = entry_open_q;
  assign bus.exit_gate_open     = exit_open_q;
  assign bus.entry_denied       = denied_q;
  assign bus.gate_timeout       = timeout_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with a fast hour clock (2 ticks/hour).
module tb_parking_gate_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   c_eopen = 0, c_xopen = 0, c_ent = 0, c_ext = 0, c_to = 0, c_den = 0, c_both = 0;
  int   b_eopen, b_xopen, b_ent, b_ext, b_to, b_den, b_both;

  parking_gate_ctrl_if bus ();

  parking_gate_ctrl #(.TICKS_PER_HOUR(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Per-cycle activity counters over registered outputs.
  always @(posedge clk) begin
    if (bus.entry_gate_open) c_eopen <= c_eopen + 1;
    if (bus.exit_gate_open)  c_xopen <= c_xopen + 1;
    if (bus.car_entered)     c_ent   <= c_ent + 1;
    if (bus.car_exited)      c_ext   <= c_ext + 1;
    if (bus.gate_timeout)    c_to    <= c_to + 1;
    if (bus.entry_denied)    c_den   <= c_den + 1;
    if (bus.car_entered && bus.car_exited) c_both <= c_both + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_eopen = c_eopen; b_xopen = c_xopen; b_ent = c_ent; b_ext = c_ext;
    b_to = c_to; b_den = c_den; b_both = c_both;
  endtask

  initial begin
    bus.entry_req = 1'b0; bus.entry_is_uni = 1'b0; bus.entry_pass = 1'b0;
    bus.exit_req = 1'b0;  bus.exit_is_uni = 1'b0;  bus.exit_pass = 1'b0;
    bus.uni_is_vacated_space = 1'b0; bus.is_vacated_space = 1'b1;
    rst = 1'b1;
    step(2);
    chk("rst_hour", 32'(bus.hour), 8);
    chk("rst_outs", {bus.car_entered, bus.is_uni_car_entered, bus.car_exited,
        bus.is_uni_car_exited, bus.entry_gate_open, bus.exit_gate_open,
        bus.entry_denied, bus.gate_timeout}, 0);

    // Hour clock: +1 every 2 cycles after reset, 23 wraps to 0.
    rst = 1'b0;
    step(1);  chk("hour_r1", 32'(bus.hour), 8);
    step(28); chk("hour_r29", 32'(bus.hour), 22);
    step(1);  chk("hour_r30", 32'(bus.hour), 23);
    step(1);  chk("hour_r31", 32'(bus.hour), 23);
    step(1);  chk("hour_wrap", 32'(bus.hour), 0);

    // Untagged entry with general space, passage so the gate stays open 5 cycles.
    snap();
    bus.entry_req = 1'b1;
    step(2); chk("e1_check_closed", 32'(bus.entry_gate_open), 0);
    step(1); chk("e1_open", 32'(bus.entry_gate_open), 1);
    step(3); bus.entry_pass = 1'b1;
    step(1); chk("e1_open_at_pass", 32'(bus.entry_gate_open), 1);
    bus.entry_pass = 1'b0;
    step(1); chk("e1_closed", 32'(bus.entry_gate_open), 0);
    chk("e1_no_early_event", 32'(bus.car_entered), 0);
    step(1); chk("e1_entered", 32'(bus.car_entered), 1);
    chk("e1_uni_q", 32'(bus.is_uni_car_entered), 0);
    bus.entry_req = 1'b0;
    step(1); chk("e1_pulse_end", 32'(bus.car_entered), 0);
    chk("e1_open_cycles", 32'(c_eopen - b_eopen), 5);
    chk("e1_event_count", 32'(c_ent - b_ent), 1);
    chk("e1_no_timeout", 32'(c_to - b_to), 0);

    // Tagged entry, no university space: denied 4 cycles, gate never opens.
    step(2); snap();
    bus.uni_is_vacated_space = 1'b0; bus.entry_is_uni = 1'b1; bus.entry_req = 1'b1;
    step(2); chk("e2_not_yet_denied", 32'(bus.entry_denied), 0);
    step(1); chk("e2_denied", 32'(bus.entry_denied), 1);
    chk("e2_gate_closed", 32'(bus.entry_gate_open), 0);
    step(3); chk("e2_denied_last", 32'(bus.entry_denied), 1);
    step(1); chk("e2_denied_drop", 32'(bus.entry_denied), 0);
    bus.entry_req = 1'b0;
    step(2);
    chk("e2_deny_cycles", 32'(c_den - b_den), 4);
    chk("e2_never_open", 32'(c_eopen - b_eopen), 0);
    chk("e2_no_event", 32'(c_ent - b_ent), 0);

    // Both lanes pass on the same edge: exit event first, entry one cycle later.
    snap();
    bus.uni_is_vacated_space = 1'b1; bus.entry_is_uni = 1'b1; bus.exit_is_uni = 1'b1;
    bus.entry_req = 1'b1; bus.exit_req = 1'b1;
    step(2); chk("e3_exit_open", 32'(bus.exit_gate_open), 1);
    chk("e3_entry_not_open", 32'(bus.entry_gate_open), 0);
    step(1); chk("e3_entry_open", 32'(bus.entry_gate_open), 1);
    bus.entry_pass = 1'b1; bus.exit_pass = 1'b1;
    step(1); bus.entry_pass = 1'b0; bus.exit_pass = 1'b0;
    step(1); chk("e3_gates_closed", {30'd0, bus.entry_gate_open, bus.exit_gate_open}, 0);
    step(1); chk("e3_exited", 32'(bus.car_exited), 1);
    chk("e3_exit_uni", 32'(bus.is_uni_car_exited), 1);
    chk("e3_entry_wait", 32'(bus.car_entered), 0);
    chk("e3_entry_uni_zero", 32'(bus.is_uni_car_entered), 0);
    step(1); chk("e3_entered", 32'(bus.car_entered), 1);
    chk("e3_entry_uni", 32'(bus.is_uni_car_entered), 1);
    chk("e3_exit_done", 32'(bus.car_exited), 0);
    chk("e3_exit_uni_zero", 32'(bus.is_uni_car_exited), 0);
    step(1); chk("e3_entry_done", 32'(bus.car_entered), 0);
    bus.entry_req = 1'b0; bus.exit_req = 1'b0;
    step(1);
    chk("e3_never_both", 32'(c_both - b_both), 0);
    chk("e3_one_entry", 32'(c_ent - b_ent), 1);
    chk("e3_one_exit", 32'(c_ext - b_ext), 1);

    // Exit opened with no passage: closes after 32 cycles with one timeout pulse.
    step(2); snap();
    bus.exit_is_uni = 1'b0; bus.exit_req = 1'b1;
    step(2);  chk("e4_open", 32'(bus.exit_gate_open), 1);
    step(31); chk("e4_still_open", 32'(bus.exit_gate_open), 1);
    chk("e4_no_early_to", 32'(bus.gate_timeout), 0);
    step(1);  chk("e4_closed", 32'(bus.exit_gate_open), 0);
    chk("e4_timeout", 32'(bus.gate_timeout), 1);
    step(1);  chk("e4_timeout_end", 32'(bus.gate_timeout), 0);
    bus.exit_req = 1'b0;
    chk("e4_open_cycles", 32'(c_xopen - b_xopen), 32);
    chk("e4_one_timeout", 32'(c_to - b_to), 1);
    chk("e4_no_exit_event", 32'(c_ext - b_ext), 0);

    // Reset while the entry gate is open, request held high throughout.
    step(2);
    bus.entry_is_uni = 1'b0; bus.entry_req = 1'b1;
    step(3); chk("e5_open", 32'(bus.entry_gate_open), 1);
    rst = 1'b1;
    step(1); chk("e5_rst_gate", 32'(bus.entry_gate_open), 0);
    chk("e5_rst_hour", 32'(bus.hour), 8);
    rst = 1'b0;
    snap();
    step(6); chk("e5_held_req_ignored", 32'(c_eopen - b_eopen), 0);
    chk("e5_no_deny", 32'(c_den - b_den), 0);
    bus.entry_req = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
